// File: rtl/alu_multicycle.sv
// Execute-stage ALU: 1-clock logic/add ops, WIDTH-step unsigned mul/div.
// Ports: clk, rst (async low), start/ready/done handshake, SrcA/SrcB/ALUControl in, ALUResult + VCNZ out.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             V,
  output logic             C,
  output logic             N,
  output logic             Z
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]         op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   rem_q;

  logic accept;
  logic load_it;
  logic load_res;
  logic is_it;
  logic last;

  assign is_it = (ALUControl[3:2] == 2'b10);
  assign last  = (cnt_q == LAST);

  // single-cycle datapath, driven straight from the inputs
  logic             is_add, is_sub, is_and;
  logic             is_or, is_xor, is_slt;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum;
  logic             slt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_v, sc_c;

  assign is_add = (ALUControl == 4'b0000);
  assign is_sub = (ALUControl == 4'b0001);
  assign is_and = (ALUControl == 4'b0010);
  assign is_or  = (ALUControl == 4'b0011);
  assign is_xor = (ALUControl == 4'b0100);
  assign is_slt = (ALUControl == 4'b0101);

  assign b_x = is_sub ? ~SrcB : SrcB;
  assign sum = {1'b0, SrcA} + {1'b0, b_x}
             + {{WIDTH{1'b0}}, is_sub};
  assign slt = $signed(SrcA) < $signed(SrcB);

  always_comb begin
    sc_res = '0;
    sc_v   = 1'b0;
    sc_c   = 1'b0;
    unique case (1'b1)
      is_add, is_sub: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (SrcA[WIDTH-1] == b_x[WIDTH-1])
              && (sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      is_and: sc_res = SrcA & SrcB;
      is_or:  sc_res = SrcA | SrcB;
      is_xor: sc_res = SrcA ^ SrcB;
      is_slt: sc_res = {{(WIDTH-1){1'b0}}, slt};
      default: sc_res = '0;
    endcase
  end

  // shift-add multiply step: multiplier sits in the low half
  logic [WIDTH:0]     add_hi;
  logic [2*WIDTH-1:0] prod_nx;

  assign add_hi  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, opnd_q}
                              : {(WIDTH+1){1'b0}});
  assign prod_nx = {add_hi, prod_q[WIDTH-1:1]};

  // restoring divide step; divisor zero leaves
  // every trial non-negative, giving all-ones / dividend
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  assign shl    = {rem_q, quo_q[WIDTH-1]};
  assign diff   = shl - {1'b0, opnd_q};
  assign rem_nx = diff[WIDTH] ? shl[WIDTH-1:0]
                              : diff[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

  logic [WIDTH-1:0] it_res;

  always_comb begin
    it_res = '0;
    unique case (op_q)
      2'b00: it_res = prod_nx[WIDTH-1:0];
      2'b01: it_res = prod_nx[2*WIDTH-1:WIDTH];
      2'b10: it_res = quo_nx;
      2'b11: it_res = rem_nx;
      default: it_res = '0;
    endcase
  end

  logic [WIDTH-1:0] res_d;
  logic             v_d, c_d;

  always_comb begin
    res_d = sc_res;
    v_d   = sc_v;
    c_d   = sc_c;
    if (state_q == ITER) begin
      res_d = it_res;
      v_d   = 1'b0;
      c_d   = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load_it  = 1'b0;
    load_res = 1'b0;
    ready    = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept = 1'b1;
          if (is_it) begin
            load_it = 1'b1;
            state_d = ITER;
          end else begin
            load_res = 1'b1;
            state_d  = DONE;
          end
        end
      end
      ITER: begin
        if (last) begin
          load_res = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= '0;
      cnt_q     <= '0;
      opnd_q    <= '0;
      prod_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      ALUResult <= '0;
      V         <= 1'b0;
      C         <= 1'b0;
      N         <= 1'b0;
      Z         <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= ALUControl[1:0];
      end
      if (load_it) begin
        cnt_q  <= '0;
        opnd_q <= ALUControl[1] ? SrcB : SrcA;
        prod_q <= {{WIDTH{1'b0}}, SrcB};
        quo_q  <= SrcA;
        rem_q  <= '0;
      end else if (state_q == ITER) begin
        cnt_q  <= cnt_q + CNT_W'(1);
        prod_q <= prod_nx;
        quo_q  <= quo_nx;
        rem_q  <= rem_nx;
      end
      if (load_res) begin
        ALUResult <= res_d;
        V         <= v_d;
        C         <= c_d;
        N         <= res_d[WIDTH-1];
        Z         <= ~|res_d;
      end
    end
  end

endmodule
